pong_match_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_key_edge_detect.sv | 25 ++
 rtl/pong_match_ctrl.sv | 147 ++++++++++++++
 tb/tb_pong_match_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer and paddle logic.
// Pure declarations, no logic or latency.
// No flow control.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      POINT     = 3'd3,
      PAUSED    = 3'd4,
      GAME_OVER = 3'd5
   } game_state_t;

   localparam logic [1:0] WINNER_NONE  = 2'b00;
   localparam logic [1:0] WINNER_LEFT  = 2'b01;
   localparam logic [1:0] WINNER_RIGHT = 2'b10;

   localparam logic [7:0] KEY_START = 8'h2C;
   localparam logic [7:0] KEY_PAUSE = 8'h13;

endpackage

// File: rtl/pong_key_edge_detect.sv
// Rising-edge detector for one keycode: pulses when KEY first appears on keycode.
// Pulse is combinational in the cycle the key appears; a held key fires once.
// No flow control.
module key_edge_detect
   import pong_pkg::*;
#(
   parameter logic [7:0] KEY = KEY_START
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   output logic       edge_pulse
);

   logic [7:0] key_prev;

   // Remember last frame's keycode so a held key only fires on its first frame.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) key_prev <= 8'h00;
      else       key_prev <= keycode;
   end

   assign edge_pulse = (keycode == KEY) && (key_prev != KEY);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve/point countdowns, pause, win detection, ball gating.
// Transitions on edge N are visible on the outputs right after edge N.
// No flow control; keys and score changes are sampled every frame.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int         WIN_SCORE    = 7,
   parameter int         PAUSE_FRAMES = 60,
   parameter logic [7:0] KEY_START    = pong_pkg::KEY_START,
   parameter logic [7:0] KEY_PAUSE    = pong_pkg::KEY_PAUSE
) (
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic [3:0] scoreL,
   input  logic [3:0] scoreR,
   output logic [2:0] game_state,
   output logic       ball_enable,
   output logic       match_rst,
   output logic [1:0] winner,
   output logic [7:0] count_out
);

   localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
   localparam logic [7:0] COUNT_VAL = 8'(PAUSE_FRAMES);

   game_state_t state, state_n;
   logic [7:0]  count, count_n;
   logic [1:0]  winner_q, winner_n;
   logic        match_rst_q, match_rst_n;
   logic [3:0]  prevL, prevR;
   logic        start_edge, pause_edge;
   logic        l_chg, r_chg;

   key_edge_detect #(.KEY(KEY_START)) u_start_edge (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .keycode    (keycode),
      .edge_pulse (start_edge)
   );

   key_edge_detect #(.KEY(KEY_PAUSE)) u_pause_edge (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .keycode    (keycode),
      .edge_pulse (pause_edge)
   );

   assign l_chg = (scoreL != prevL);
   assign r_chg = (scoreR != prevR);

   // Track scores every frame so changes outside PLAY never queue up as points.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         prevL <= 4'd0;
         prevR <= 4'd0;
      end else begin
         prevL <= scoreL;
         prevR <= scoreR;
      end
   end

   // State, countdown, winner and match_rst pulse registers.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         count       <= 8'd0;
         winner_q    <= WINNER_NONE;
         match_rst_q <= 1'b0;
      end else begin
         state       <= state_n;
         count       <= count_n;
         winner_q    <= winner_n;
         match_rst_q <= match_rst_n;
      end
   end

   // Next-state logic; PLAY priority is left win, right win, point, pause.
   always_comb begin
      state_n     = state;
      count_n     = count;
      winner_n    = winner_q;
      match_rst_n = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge) begin
               state_n     = SERVE;
               count_n     = COUNT_VAL;
               winner_n    = WINNER_NONE;
               match_rst_n = 1'b1;
            end
         end
         SERVE, POINT: begin
            // Leaving at count<=1 keeps count from ever wrapping below zero.
            if (count <= 8'd1) begin
               state_n = PLAY;
               count_n = 8'd0;
            end else begin
               count_n = count - 8'd1;
            end
         end
         PLAY: begin
            if (l_chg && (scoreL >= WIN_VAL)) begin
               state_n  = GAME_OVER;
               winner_n = WINNER_LEFT;
            end else if (r_chg && (scoreR >= WIN_VAL)) begin
               state_n  = GAME_OVER;
               winner_n = WINNER_RIGHT;
            end else if (l_chg || r_chg) begin
               state_n = POINT;
               count_n = COUNT_VAL;
            end else if (pause_edge) begin
               state_n = PAUSED;
            end
         end
         PAUSED: begin
            if (pause_edge) begin
               state_n = PLAY;
            end else if (start_edge) begin
               state_n     = SERVE;
               count_n     = COUNT_VAL;
               winner_n    = WINNER_NONE;
               match_rst_n = 1'b1;
            end
         end
         GAME_OVER: begin
            if (start_edge) begin
               state_n     = SERVE;
               count_n     = COUNT_VAL;
               winner_n    = WINNER_NONE;
               match_rst_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            count_n = 8'd0;
         end
      endcase
   end

   assign game_state  = state;
   assign ball_enable = (state == PLAY);
   assign match_rst   = match_rst_q;
   assign winner      = winner_q;
   assign count_out   = ((state == SERVE) || (state == POINT)) ? count : 8'd0;

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

   localparam int PF  = 4;
   localparam int WIN = 3;

   localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                          S_POINT = 3'd3, S_PAUSED = 3'd4, S_OVER = 3'd5;
   localparam logic [7:0] K_ST = 8'h2C, K_PA = 8'h13, K_NO = 8'h00;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic       ben;
      logic       mrst;
      logic [1:0] win;
      logic [7:0] cnt;
   } exp_t;

   logic       Reset;
   logic       frame_clk;
   logic [7:0] keycode;
   logic [3:0] scoreL, scoreR;
   logic [2:0] game_state;
   logic       ball_enable, match_rst;
   logic [1:0] winner;
   logic [7:0] count_out;

   int checks   = 0;
   int failures = 0;
   exp_t sb[$];

   pong_match_ctrl #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF)) dut (
      .Reset       (Reset),
      .frame_clk   (frame_clk),
      .keycode     (keycode),
      .scoreL      (scoreL),
      .scoreR      (scoreR),
      .game_state  (game_state),
      .ball_enable (ball_enable),
      .match_rst   (match_rst),
      .winner      (winner),
      .count_out   (count_out)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input exp_t e);
      check({e.tag, ".state"}, 32'(game_state), 32'(e.st));
      check({e.tag, ".ben"},   32'(ball_enable), 32'(e.ben));
      check({e.tag, ".mrst"},  32'(match_rst), 32'(e.mrst));
      check({e.tag, ".win"},   32'(winner), 32'(e.win));
      check({e.tag, ".cnt"},   32'(count_out), 32'(e.cnt));
   endtask

   // Drive one frame of inputs, record what should come out after the edge,
   // then pop and compare once the DUT has clocked.
   task automatic step(input string tag, input logic [7:0] k, input logic [3:0] sl,
                       input logic [3:0] sr, input logic [2:0] st, input logic ben,
                       input logic mrst, input logic [1:0] win, input logic [7:0] cnt);
      exp_t e, got;
      keycode = k;
      scoreL  = sl;
      scoreR  = sr;
      e.tag = tag; e.st = st; e.ben = ben; e.mrst = mrst; e.win = win; e.cnt = cnt;
      sb.push_back(e);
      @(posedge frame_clk);
      #1;
      got = sb.pop_front();
      check_outputs(got);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      exp_t r;
      r.tag = "reset"; r.st = S_IDLE; r.ben = 0; r.mrst = 0; r.win = 2'b00; r.cnt = 0;
      Reset = 1'b1; keycode = K_NO; scoreL = 0; scoreR = 0;
      #3;
      check_outputs(r);
      @(posedge frame_clk); #1;
      check_outputs(r);
      #6 Reset = 1'b0;
      step("idle", K_NO, 0, 0, S_IDLE, 0, 0, 2'b00, 0);

      // 1: start, serve countdown 4..1, then play
      step("t1.s4", K_ST, 0, 0, S_SERVE, 0, 1, 2'b00, 4);
      step("t1.s3", K_NO, 0, 0, S_SERVE, 0, 0, 2'b00, 3);
      step("t1.s2", K_NO, 0, 0, S_SERVE, 0, 0, 2'b00, 2);
      step("t1.s1", K_NO, 0, 0, S_SERVE, 0, 0, 2'b00, 1);
      step("t1.play", K_NO, 0, 0, S_PLAY, 1, 0, 2'b00, 0);
      step("t1.hold", K_NO, 0, 0, S_PLAY, 1, 0, 2'b00, 0);

      // 2: right scores, point pause
      step("t2.p4", K_NO, 0, 1, S_POINT, 0, 0, 2'b00, 4);
      step("t2.p3", K_NO, 0, 1, S_POINT, 0, 0, 2'b00, 3);
      step("t2.p2", K_NO, 0, 1, S_POINT, 0, 0, 2'b00, 2);
      step("t2.p1", K_NO, 0, 1, S_POINT, 0, 0, 2'b00, 1);
      step("t2.play", K_NO, 0, 1, S_PLAY, 1, 0, 2'b00, 0);

      // left to 2 (below win), then 2->3 wins
      step("t3.pt", K_NO, 2, 1, S_POINT, 0, 0, 2'b00, 4);
      for (int i = 3; i >= 1; i--)
         step("t3.cd", K_NO, 2, 1, S_POINT, 0, 0, 2'b00, 8'(i));
      step("t3.play", K_NO, 2, 1, S_PLAY, 1, 0, 2'b00, 0);
      step("t3.win", K_NO, 3, 1, S_OVER, 0, 0, 2'b01, 0);
      step("t3.held", K_NO, 3, 1, S_OVER, 0, 0, 2'b01, 0);
      step("t3.rst", K_ST, 3, 1, S_SERVE, 0, 1, 2'b00, 4);
      step("t3.clr", K_NO, 0, 0, S_SERVE, 0, 0, 2'b00, 3);
      step("t3.s2", K_NO, 0, 0, S_SERVE, 0, 0, 2'b00, 2);
      step("t3.s1", K_NO, 0, 0, S_SERVE, 0, 0, 2'b00, 1);
      step("t3.play", K_NO, 0, 0, S_PLAY, 1, 0, 2'b00, 0);

      // 4: pause held 10 frames, scores ignored while paused
      step("t4.pause", K_PA, 0, 0, S_PAUSED, 0, 0, 2'b00, 0);
      for (int i = 0; i < 9; i++)
         step("t4.held", K_PA, (i >= 4) ? 4'd1 : 4'd0, 0, S_PAUSED, 0, 0, 2'b00, 0);
      step("t4.rel", K_NO, 1, 0, S_PAUSED, 0, 0, 2'b00, 0);
      step("t4.resume", K_PA, 1, 0, S_PLAY, 1, 0, 2'b00, 0);
      step("t4.nopt", K_NO, 1, 0, S_PLAY, 1, 0, 2'b00, 0);

      // both change at once, left below win -> point
      step("t4.both", K_NO, 2, 1, S_POINT, 0, 0, 2'b00, 4);
      for (int i = 3; i >= 1; i--)
         step("t4.cd", K_NO, 2, 1, S_POINT, 0, 0, 2'b00, 8'(i));
      step("t4.play", K_NO, 2, 1, S_PLAY, 1, 0, 2'b00, 0);
      // both reach win together -> left evaluated first
      step("t4.tie", K_NO, 3, 3, S_OVER, 0, 0, 2'b01, 0);

      // 5: start held continuously: one pulse, no restart in GAME_OVER
      step("t5.rst", K_ST, 3, 3, S_SERVE, 0, 1, 2'b00, 4);
      step("t5.s3", K_ST, 0, 0, S_SERVE, 0, 0, 2'b00, 3);
      step("t5.s2", K_ST, 0, 0, S_SERVE, 0, 0, 2'b00, 2);
      step("t5.s1", K_ST, 0, 0, S_SERVE, 0, 0, 2'b00, 1);
      step("t5.play", K_ST, 0, 0, S_PLAY, 1, 0, 2'b00, 0);
      step("t5.rwin", K_ST, 0, 3, S_OVER, 0, 0, 2'b10, 0);
      for (int i = 0; i < 3; i++)
         step("t5.held", K_ST, 0, 3, S_OVER, 0, 0, 2'b10, 0);
      step("t5.rel", K_NO, 0, 3, S_OVER, 0, 0, 2'b10, 0);
      step("t5.again", K_ST, 0, 3, S_SERVE, 0, 1, 2'b00, 4);

      // 6: reset mid-serve at count 2
      step("t6.s3", K_NO, 0, 0, S_SERVE, 0, 0, 2'b00, 3);
      step("t6.s2", K_NO, 0, 0, S_SERVE, 0, 0, 2'b00, 2);
      Reset = 1'b1;
      #1;
      r.tag = "t6.arst";
      check_outputs(r);
      @(posedge frame_clk); #1;
      r.tag = "t6.hold";
      check_outputs(r);
      #3 Reset = 1'b0;
      step("t6.idle", K_NO, 0, 0, S_IDLE, 0, 0, 2'b00, 0);
      step("t6.idle2", K_NO, 0, 0, S_IDLE, 0, 0, 2'b00, 0);

      check("sb.empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
